sync_fifo_param: RTL

- Parametrised single-clock FIFO; next generation of the team's 2-entry handshake FIFO.
- Configurable data width, depth and threshold flags.
- Supports simultaneous read and write in one cycle and reports occupancy.
- Sits between producer/consumer blocks using the en/rdy handshake; data is show-ahead, so the head word is always visible on read_data.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_mem_2p.sv | 30 +++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family:
// default geometry, pointer/count width helpers and the pointer wrap rule.
package fifo_pkg;

   // Default geometry used when a parent does not override the parameters
   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   // Bits needed to address DEPTH entries (never less than one bit)
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Bits needed to hold an occupancy from 0 up to and including DEPTH
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointer advance with explicit wrap, so non-power-of-two depths work
   function automatic int ptr_inc(input int p, input int depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH storage for the FIFO: registered write port, asynchronous
// (combinational) read port. Contents are intentionally not reset.
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = ptr_w(DEPTH)
) (
   input  logic             CLK,
   input  logic             write_en,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic [AW-1:0]    read_addr,
   output logic [WIDTH-1:0] read_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Store the incoming word on an accepted write
   always_ff @(posedge CLK) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   // Head word is read combinationally so the FIFO can present it show-ahead
   assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with en/rdy handshakes,
// occupancy count and almost-full / almost-empty thresholds.
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN enables the sticky
// overflow/underflow flags; without it both outputs are tied low.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       write_en,
   input  logic [WIDTH-1:0]           write_data,
   output logic                       write_rdy,
   input  logic                       read_en,
   output logic [WIDTH-1:0]           read_data,
   output logic                       read_rdy,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] mem_rdata;

   // Handshake flags come straight from the registered count, so a write and
   // a read on the same edge are both judged against the pre-edge occupancy.
   assign write_rdy = (count != FULL_CNT);
   assign read_rdy  = (count != '0);
   assign wr_acc    = write_en && write_rdy;
   assign rd_acc    = read_en && read_rdy;

   // Threshold flags decode registered count only, keeping them glitch-free
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);

   // Empty FIFO shows zero rather than whatever stale word rptr points at
   assign read_data = read_rdy ? mem_rdata : '0;

   // Write and read pointers advance independently on accepted transfers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) begin
            wptr <= PW'(ptr_inc(int'(wptr), DEPTH));
         end
         if (rd_acc) begin
            rptr <= PW'(ptr_inc(int'(rptr), DEPTH));
         end
      end
   end

   // Occupancy: a simultaneous accepted write and read leave it unchanged
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= '0;
      end else begin
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fifo_mem_2p #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .CLK        (CLK),
      .write_en   (wr_acc),
      .write_addr (wptr),
      .write_data (write_data),
      .read_addr  (rptr),
      .read_data  (mem_rdata)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   // Sticky protocol-error flags: any request made while not ready latches
   // the matching flag one cycle later; only RST clears them.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (write_en && !write_rdy) begin
            overflow <= 1'b1;
         end
         if (read_en && !read_rdy) begin
            underflow <= 1'b1;
         end
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule
